// File: rtl/ldpc_sched_pkg.sv
// Shared types and helpers for the column-layered LDPC iteration scheduler.
package ldpc_sched_pkg;
  localparam int COL_N_DEF    = 24;
  localparam int MAX_ITER_DEF = 8;
  localparam int COL_W        = $clog2(COL_N_DEF);
  localparam int ITER_W       = $clog2(MAX_ITER_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } sched_st_e;

  // Requested limit of 0 still runs one iteration; anything above the ceiling saturates.
  function automatic int clamp_lim(input int req, input int max_it);
    if (req < 1) return 1;
    if (req > max_it) return max_it;
    return req;
  endfunction
endpackage

// File: rtl/ldpc_vld_delay.sv
// DEPTH-stage {valid, addr} shift register with enable and synchronous clear.
module ldpc_vld_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr,
  output logic          o_vld,
  output logic [AW-1:0] o_addr,
  output logic          o_pend
);
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH:0]           vld_nxt;
  logic [DEPTH:0][AW-1:0]   addr_nxt;

  assign vld_nxt  = {vld_q, i_vld};
  assign addr_nxt = {addr_q, i_addr};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else if (i_en) begin
      vld_q  <= vld_nxt[DEPTH-1:0];
      addr_q <= addr_nxt[DEPTH-1:0];
    end
  end

  assign o_vld  = vld_q[DEPTH-1];
  assign o_addr = addr_q[DEPTH-1];
  // Anything still in flight behind the output stage.
  assign o_pend = |(vld_q & ~(DEPTH'(1) << (DEPTH - 1)));
endmodule

// File: rtl/ldpc_col_sched.sv
// Column-layer / iteration scheduler: read sweep, aligned write-back, syndrome gate.
// Optional early termination on syndrome pass: define LDPC_EARLY_TERM_EN.
module ldpc_col_sched #(
  parameter int COL_N    = ldpc_sched_pkg::COL_N_DEF,
  parameter int MAX_ITER = ldpc_sched_pkg::MAX_ITER_DEF,
  parameter int PIPE_LAT = 2,
  parameter int COL_W    = $clog2(COL_N),
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_stall,
  input  logic              i_syn_vld,
  input  logic              i_syn_ok,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_et,
  output logic              o_rd_en,
  output logic [COL_W-1:0]  o_rd_addr,
  output logic              o_wr_en,
  output logic [COL_W-1:0]  o_wr_addr,
  output logic              o_first_iter,
  output logic [ITER_W-1:0] o_iter
);
  import ldpc_sched_pkg::*;

  sched_st_e         st, st_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [ITER_W-1:0] iter, iter_nxt, lim, lim_nxt;
  logic              et, et_nxt;
  logic              rd_en, dl_vld, dl_pend;

`ifndef LDPC_EARLY_TERM_EN
  logic unused_syn_ok;
  assign unused_syn_ok = i_syn_ok;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st   <= ST_IDLE;
      col  <= '0;
      iter <= '0;
      lim  <= '0;
      et   <= 1'b0;
    end else begin
      st   <= st_nxt;
      col  <= col_nxt;
      iter <= iter_nxt;
      lim  <= lim_nxt;
      et   <= et_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    col_nxt  = col;
    iter_nxt = iter;
    lim_nxt  = lim;
    et_nxt   = et;
    rd_en    = 1'b0;
    case (st)
      ST_IDLE: if (i_start) begin
        lim_nxt  = ITER_W'(clamp_lim(int'(i_max_iter), MAX_ITER));
        col_nxt  = '0;
        iter_nxt = '0;
        et_nxt   = 1'b0;
        st_nxt   = ST_RUN;
      end
      ST_RUN: if (!i_stall) begin
        rd_en   = 1'b1;
        col_nxt = col + COL_W'(1);
        if (col == COL_W'(COL_N - 1)) st_nxt = ST_DRAIN;
      end
      // Output stage may still hold the last write; it leaves on this same edge.
      ST_DRAIN: if (!i_stall && !dl_pend) st_nxt = ST_CHECK;
      ST_CHECK: if (!i_stall && i_syn_vld) begin
`ifdef LDPC_EARLY_TERM_EN
        if (i_syn_ok) begin
          et_nxt = 1'b1;
          st_nxt = ST_DONE;
        end else
`endif
        if (iter + ITER_W'(1) == lim) begin
          st_nxt = ST_DONE;
        end else begin
          iter_nxt = iter + ITER_W'(1);
          col_nxt  = '0;
          st_nxt   = ST_RUN;
        end
      end
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  ldpc_vld_delay #(.DEPTH(PIPE_LAT), .AW(COL_W)) u_wr_dly (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (!i_stall),
    .i_clr  (1'b0),
    .i_vld  (rd_en),
    .i_addr (col),
    .o_vld  (dl_vld),
    .o_addr (o_wr_addr),
    .o_pend (dl_pend)
  );

  assign o_busy       = (st == ST_RUN) || (st == ST_DRAIN) || (st == ST_CHECK);
  assign o_done       = (st == ST_DONE);
  assign o_rd_en      = rd_en;
  assign o_rd_addr    = col;
  assign o_wr_en      = dl_vld && !i_stall;
  assign o_first_iter = o_busy && (iter == '0);
  assign o_iter       = iter;
`ifdef LDPC_EARLY_TERM_EN
  assign o_et         = et;
`else
  assign o_et         = 1'b0;
`endif
endmodule

// File: tb/tb_ldpc_col_sched.sv
// Randomized bench for ldpc_col_sched against a timestamped read/write-back queue model.
module tb_ldpc_col_sched;
  localparam int COL_N    = 24;
  localparam int MAX_ITER = 8;
  localparam int PIPE_LAT = 2;
  localparam int COL_W    = $clog2(COL_N);
  localparam int ITER_W   = $clog2(MAX_ITER + 1);
`ifdef LDPC_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n, i_start, i_stall, i_syn_vld, i_syn_ok;
  logic [ITER_W-1:0] i_max_iter;
  logic              o_busy, o_done, o_et, o_rd_en, o_wr_en, o_first_iter;
  logic [COL_W-1:0]  o_rd_addr, o_wr_addr;
  logic [ITER_W-1:0] o_iter;

  ldpc_col_sched #(.COL_N(COL_N), .MAX_ITER(MAX_ITER), .PIPE_LAT(PIPE_LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_max_iter(i_max_iter),
    .i_stall(i_stall), .i_syn_vld(i_syn_vld), .i_syn_ok(i_syn_ok),
    .o_busy(o_busy), .o_done(o_done), .o_et(o_et), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_first_iter(o_first_iter), .o_iter(o_iter)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at t=%0t", tag, got, exp, $time);
  endtask

  // Reference: phase 0 idle, 1 sweeping reads, 2 waiting for write-backs,
  // 3 waiting for syndrome, 4 completion cycle. Each read schedules its
  // write-back PIPE_LAT unstalled cycles later (ns counts unstalled cycles).
  typedef struct { int addr; int due; } wb_t;
  wb_t wq[$];
  int  m_ph = 0, m_col = 0, m_iter = 0, m_lim = 1, ns = 0;
  bit  m_et = 1'b0, after_rst = 1'b0;
  int  rd_cnt, done_cnt;

  task automatic cyc(input bit rst_n, input bit start, input int maxit,
                     input bit stall, input bit sv, input bit sok);
    bit busy, erd, ewr;
    @(negedge i_clk);
    i_rst_n = rst_n; i_start = start; i_max_iter = ITER_W'(maxit);
    i_stall = stall; i_syn_vld = sv; i_syn_ok = sok;
    #1;
    if (!rst_n) begin
      m_ph = 0; m_col = 0; m_iter = 0; m_et = 1'b0; wq.delete();
      after_rst = 1'b1;
      return;
    end
    if (after_rst) begin
      chk("rst_rd_addr", o_rd_addr, 0);
      chk("rst_wr_addr", o_wr_addr, 0);
      after_rst = 1'b0;
    end
    busy = (m_ph >= 1) && (m_ph <= 3);
    erd  = (m_ph == 1) && !stall;
    ewr  = !stall && (wq.size() != 0) && (wq[0].due == ns);
    chk("rd_en", o_rd_en, erd);
    if (erd) chk("rd_addr", o_rd_addr, m_col);
    chk("wr_en", o_wr_en, ewr);
    if (ewr) chk("wr_addr", o_wr_addr, wq[0].addr);
    chk("busy", o_busy, busy);
    chk("done", o_done, m_ph == 4);
    chk("iter", o_iter, m_iter);
    chk("first_iter", o_first_iter, busy && (m_iter == 0));
    chk("et", o_et, m_et);
    if (o_rd_en) rd_cnt++;
    if (o_done) done_cnt++;
    if (ewr) void'(wq.pop_front());
    case (m_ph)
      0: if (start) begin
        m_lim = (maxit < 1) ? 1 : ((maxit > MAX_ITER) ? MAX_ITER : maxit);
        m_col = 0; m_iter = 0; m_et = 1'b0; m_ph = 1;
      end
      1: if (!stall) begin
        wq.push_back('{addr: m_col, due: ns + PIPE_LAT});
        m_col++;
        if (m_col == COL_N) m_ph = 2;
      end
      2: if (!stall && wq.size() == 0) m_ph = 3;
      3: if (!stall && sv) begin
        if (ET && sok) begin m_et = 1'b1; m_ph = 4; end
        else if (m_iter + 1 == m_lim) m_ph = 4;
        else begin m_iter++; m_col = 0; m_ph = 1; end
      end
      default: m_ph = 0;
    endcase
    if (!stall) ns++;
  endtask

  // ok_iter: 1-based iteration whose syndrome reports ok (0 or out of range: never).
  task automatic run_frame(input int maxit, input int stall_pct, input int sv_pct,
                           input int ok_iter, input bit hs, input bit stall_at, input bit rst_at);
    int lim, exp_it, budget, stall_left;
    bit did_stall, st, sv, so, go;
    lim    = (maxit < 1) ? 1 : ((maxit > MAX_ITER) ? MAX_ITER : maxit);
    exp_it = (ET && ok_iter >= 1 && ok_iter <= lim) ? ok_iter : lim;
    rd_cnt = 0; done_cnt = 0; stall_left = 0; did_stall = 1'b0; budget = 0;
    cyc(1'b1, 1'b1, maxit, 1'($urandom_range(1)), 1'b0, 1'b0);
    while (m_ph != 0 && budget < 4000) begin
      budget++;
      st = (m_ph >= 1 && m_ph <= 3) && ($urandom_range(99) < stall_pct);
      if (stall_at && !did_stall && m_ph == 1 && m_iter == 0 && m_col == 11) begin
        stall_left = 5; did_stall = 1'b1;
      end
      if (stall_left > 0) begin st = 1'b1; stall_left--; end
      sv = ($urandom_range(99) < sv_pct);
      so = (m_iter + 1 == ok_iter);
      go = hs && (m_ph == 4 || $urandom_range(9) == 0);
      if (rst_at && m_ph == 1 && m_iter == 1 && m_col == 7) begin
        cyc(1'b0, 1'b0, maxit, 1'b0, 1'b0, 1'b0);
        return;
      end
      cyc(1'b1, go, maxit, st, sv, so);
    end
    chk("frame_timeout", int'(budget < 4000), 1);
    chk("frame_rd_cnt", rd_cnt, exp_it * COL_N);
    chk("frame_done_cnt", done_cnt, 1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_max_iter = '0;
    i_stall = 1'b0; i_syn_vld = 1'b0; i_syn_ok = 1'b0;
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0);

    run_frame(3, 0, 50, 0, 1'b0, 1'b0, 1'b0);      // basic three sweeps
    run_frame(0, 0, 60, 0, 1'b0, 1'b0, 1'b0);      // limit 0 -> 1 iteration
    run_frame(15, 0, 60, 0, 1'b0, 1'b0, 1'b0);     // limit 15 -> 8 iterations
    run_frame(8, 0, 60, 2, 1'b0, 1'b0, 1'b0);      // syndrome ok after iteration 2
    run_frame(1, 0, 60, 0, 1'b0, 1'b1, 1'b0);      // 5-cycle stall after rd 10
    run_frame(2, 0, 60, 0, 1'b1, 1'b0, 1'b0);      // stray starts, then back-to-back
    run_frame(1, 0, 60, 0, 1'b0, 1'b0, 1'b0);
    run_frame(3, 0, 60, 0, 1'b0, 1'b0, 1'b1);      // reset in iteration 1 at col 7
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    run_frame(2, 0, 60, 0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 8; f++)
      run_frame(int'($urandom_range(15)), 20, 40, int'($urandom_range(9)),
                1'($urandom_range(1)), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
